reward_tx_serializer: RTL and testbench
=======================================

Name: reward_tx_serializer

Overview:
- Sits directly downstream of the reward packing block.
- When reward signals done, it captures the eight packed packet words and appends an XOR checksum word.
- It then streams the nine words, one per handshake, over a 16-bit valid/ready link to the radio/MAC interface.
- It enforces a programmable inter-frame gap and counts packets it drops because they arrive while busy.

Parameters:
- WORD_WIDTH, 16, width of every packet word and of tx_data.
- IFG_CYCLES, 4, idle cycles forced after the last word before a new packet is accepted (0 allowed).
- DROP_CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- nrst  input  1  reset, synchronous, active-low.
- reward_done  input  1  single-cycle pulse: the r* words are valid this cycle.
- rDestinationID  input  WORD_WIDTH  packed destination ID.
- rSourceID  input  WORD_WIDTH  packed source ID.
- rPacketType  input  WORD_WIDTH  packed packet type.
- rSourceHops  input  WORD_WIDTH  packed hops from sink.
- rQValue  input  WORD_WIDTH  packed Q-value.
- rEnergyLeft  input  WORD_WIDTH  packed residual energy.
- rChosenCH  input  WORD_WIDTH  packed chosen cluster head.
- rHopsFromCH  input  WORD_WIDTH  packed hops from CH.
- tx_ready  input  1  downstream can accept tx_data this cycle.
- tx_valid  output  1  tx_data holds a valid word.
- tx_data  output  WORD_WIDTH  current packet word.
- tx_last  output  1  current word is the checksum (word 8).
- tx_busy  output  1  high in SEND and GAP; reward must not be re-enabled while high.
- pkt_sent  output  1  one-cycle pulse after the checksum word handshakes.
- drop_count  output  DROP_CNT_WIDTH  saturating count of rejected reward_done pulses.

Behaviour:
- Clock and reset: one clock (clk). Reset nrst is synchronous, active-low, sampled on the clk rising edge.
- Reset values: state=IDLE, word index=0, capture registers=0, tx_valid=0, tx_data=0, tx_last=0, tx_busy=0, pkt_sent=0, drop_count=0.
- Reset mid-packet aborts immediately: no further words are sent and the packet is lost, not counted as a drop.
- States: IDLE, SEND, GAP.
- IDLE: reward_done=1 captures all eight words plus checksum into registers and moves to SEND.
  - checksum = XOR of the eight words, in full WORD_WIDTH, no carry.
- SEND, entry: first SEND cycle (one cycle after reward_done) presents tx_valid=1 and word 0.
- SEND, word order (index 0..8): DestinationID, SourceID, PacketType, SourceHops, QValue, EnergyLeft, ChosenCH, HopsFromCH, checksum.
- SEND, handshake: a word transfers on a cycle with tx_valid&tx_ready; the index then increments and the next word appears the following cycle.
- SEND, back-to-back: tx_ready held high gives nine words in nine consecutive cycles.
- SEND, stall: with tx_ready=0, tx_data, tx_last and tx_valid hold stable; tx_valid never drops mid-packet.
- SEND, exit: tx_last=1 only while index=8. On its handshake:
  - tx_valid falls next cycle;
  - pkt_sent pulses high for exactly one cycle (the cycle after the handshake);
  - state goes to GAP with counter=IFG_CYCLES, or straight to IDLE if IFG_CYCLES=0.
- GAP: counter decrements by one per cycle; at 0 the state returns to IDLE. tx_valid=0 throughout.
- Captured words are independent of later r* input changes.
- Drops: reward_done=1 while state is SEND or GAP is ignored (capture registers untouched) and drop_count increments.
  - drop_count saturates at all-ones; it never wraps.
- Simultaneous events:
  - reward_done in the same cycle GAP reaches 0 or the last handshake occurs is dropped, since state is not yet IDLE.
  - reward_done in the first IDLE cycle is accepted.
- tx_busy=1 exactly when state is SEND or GAP.
- Latency: reward_done to first tx_valid = 1 cycle.
- Minimum packet period = 1 + 9 + IFG_CYCLES cycles with tx_ready held high.

Test Plan:
- Basic packet: reset, tx_ready=1, words 0x0001..0x0008 in port order with reward_done pulse.
  - Expect tx_data sequence 0x0001,0x0002,...,0x0008,0x0008 (XOR of 1..8 = 0x0008).
  - tx_last only on the 9th word; pkt_sent pulse one cycle later.
- Backpressure: same packet, tx_ready toggled 1,0,0,1,...
  - Expect each word held stable while tx_ready=0, no word skipped or repeated.
  - tx_valid continuously high until the checksum handshake.
- Inter-frame gap with IFG_CYCLES=4: second reward_done arriving 2 cycles after pkt_sent is dropped (drop_count=1).
  - A reward_done arriving 5 cycles after the last handshake is accepted.
- Drop saturation with DROP_CNT_WIDTH=8: hold tx_ready=0 mid-packet and pulse reward_done 300 times.
  - Expect drop_count=255; the original packet completes unchanged once tx_ready=1.
- Reset mid-packet: assert nrst=0 for one clk edge after word 3 transfers.
  - Expect all outputs 0 next cycle, state IDLE, and a fresh packet accepted afterwards with word 0 first.
- Input isolation: change all r* inputs to 0xFFFF the cycle after capture.
  - Expect the transmitted packet to carry the originally captured values and checksum.

Source files
------------

// File: rtl/reward_tx_serializer.sv
// Captures one packed reward packet, appends an XOR checksum word and streams the
// nine words over a valid/ready link, then holds off new packets for an inter-frame gap.
module reward_tx_serializer #(
    parameter int WORD_WIDTH     = 16,
    parameter int IFG_CYCLES     = 4,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      reward_done,
    input  logic [WORD_WIDTH-1:0]     rDestinationID,
    input  logic [WORD_WIDTH-1:0]     rSourceID,
    input  logic [WORD_WIDTH-1:0]     rPacketType,
    input  logic [WORD_WIDTH-1:0]     rSourceHops,
    input  logic [WORD_WIDTH-1:0]     rQValue,
    input  logic [WORD_WIDTH-1:0]     rEnergyLeft,
    input  logic [WORD_WIDTH-1:0]     rChosenCH,
    input  logic [WORD_WIDTH-1:0]     rHopsFromCH,
    input  logic                      tx_ready,
    output logic                      tx_valid,
    output logic [WORD_WIDTH-1:0]     tx_data,
    output logic                      tx_last,
    output logic                      tx_busy,
    output logic                      pkt_sent,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam int                 NUM_WORDS = 9;
    localparam int                 GAP_W     = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0]   GAP_LOAD  = GAP_W'(IFG_CYCLES);
    localparam logic [3:0]         LAST_IDX  = 4'd8;

    state_t                      state_q, state_d;
    logic [3:0]                  idx_q, idx_d;
    logic [WORD_WIDTH-1:0]       words_q [NUM_WORDS];
    logic [WORD_WIDTH-1:0]       words_d [NUM_WORDS];
    logic [GAP_W-1:0]            gap_q, gap_d;
    logic [DROP_CNT_WIDTH-1:0]   drop_q, drop_d;
    logic                        pkt_sent_q, pkt_sent_d;
    logic [WORD_WIDTH-1:0]       word_sel;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            gap_q      <= '0;
            drop_q     <= '0;
            pkt_sent_q <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                words_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            drop_q     <= drop_d;
            pkt_sent_q <= pkt_sent_d;
            for (int i = 0; i < NUM_WORDS; i++) begin
                words_q[i] <= words_d[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        drop_d     = drop_q;
        pkt_sent_d = 1'b0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            words_d[i] = words_q[i];
        end

        case (state_q)
            IDLE: begin
                if (reward_done) begin
                    words_d[0] = rDestinationID;
                    words_d[1] = rSourceID;
                    words_d[2] = rPacketType;
                    words_d[3] = rSourceHops;
                    words_d[4] = rQValue;
                    words_d[5] = rEnergyLeft;
                    words_d[6] = rChosenCH;
                    words_d[7] = rHopsFromCH;
                    words_d[8] = rDestinationID ^ rSourceID ^ rPacketType ^ rSourceHops ^
                                 rQValue ^ rEnergyLeft ^ rChosenCH ^ rHopsFromCH;
                    idx_d      = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                // tx_valid is always high here, so tx_ready alone marks a handshake
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        pkt_sent_d = 1'b1;
                        idx_d      = '0;
                        if (IFG_CYCLES == 0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = GAP;
                            gap_d   = GAP_LOAD;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            GAP: begin
                // The cycle the counter reaches zero is the last GAP cycle
                if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reward_done && (state_q != IDLE) && (drop_q != '1)) begin
            drop_d = drop_q + DROP_CNT_WIDTH'(1);
        end
    end

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (idx_q == 4'(i)) begin
                word_sel = words_q[i];
            end
        end
    end

    assign tx_valid   = (state_q == SEND);
    assign tx_last    = (state_q == SEND) && (idx_q == LAST_IDX);
    assign tx_data    = (state_q == SEND) ? word_sel : '0;
    assign tx_busy    = (state_q != IDLE);
    assign pkt_sent   = pkt_sent_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_reward_tx_serializer.sv
// Bench for reward_tx_serializer: queue-based packet model checked every cycle,
// plus directed packets with hand-computed word sequences.
module tb_reward_tx_serializer;

    localparam int W   = 16;
    localparam int IFG = 4;
    localparam int DW  = 8;
    localparam int DROP_MAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          reward_done = 1'b0;
    logic          tx_ready = 1'b0;
    logic [W-1:0]  r [8];
    logic          tx_valid, tx_last, tx_busy, pkt_sent;
    logic [W-1:0]  tx_data;
    logic [DW-1:0] drop_count;

    reward_tx_serializer #(.WORD_WIDTH(W), .IFG_CYCLES(IFG), .DROP_CNT_WIDTH(DW)) dut (
        .clk(clk), .nrst(nrst), .reward_done(reward_done),
        .rDestinationID(r[0]), .rSourceID(r[1]), .rPacketType(r[2]), .rSourceHops(r[3]),
        .rQValue(r[4]), .rEnergyLeft(r[5]), .rChosenCH(r[6]), .rHopsFromCH(r[7]),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
        .tx_busy(tx_busy), .pkt_sent(pkt_sent), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Packet model: a queue of words still owed, a count of words sent, and the
    // number of forced idle cycles remaining after a packet.
    logic [W-1:0] mq [$];
    bit           m_inflight = 0;
    int           m_nsent = 0;
    int           m_gap = 0;
    bit           m_pkt = 0;
    int           m_drop = 0;
    bit           m_ok = 0;
    bit           m_busy_pre;
    logic [W-1:0] m_sum;

    int checks_m = 0, errors_m = 0;
    int checks_d = 0, errors_d = 0;
    int cyc = 0;

    logic [W-1:0] log_data [$];
    bit           log_last [$];

    always @(posedge clk) begin
        cyc++;
        if (!nrst) begin
            mq.delete();
            m_inflight = 0; m_nsent = 0; m_gap = 0; m_pkt = 0; m_drop = 0;
            m_ok = 1;
        end else begin
            m_busy_pre = m_inflight || (m_gap > 0);
            m_pkt = 0;
            if (m_gap > 0) m_gap--;
            if (m_inflight && tx_ready) begin
                void'(mq.pop_front());
                m_nsent++;
                if (m_nsent == 9) begin
                    m_inflight = 0; m_nsent = 0; m_gap = IFG; m_pkt = 1;
                end
            end
            if (reward_done) begin
                if (m_busy_pre) begin
                    if (m_drop < DROP_MAX) m_drop++;
                end else begin
                    m_sum = '0;
                    for (int i = 0; i < 8; i++) begin
                        mq.push_back(r[i]);
                        m_sum = m_sum ^ r[i];
                    end
                    mq.push_back(m_sum);
                    m_inflight = 1; m_nsent = 0;
                end
            end
        end
    end

    task automatic mchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_m++;
        if (act !== exp) begin
            errors_m++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_ok) begin
            mchk("tx_valid", 32'(tx_valid), 32'(m_inflight));
            mchk("tx_busy", 32'(tx_busy), 32'(m_inflight || (m_gap > 0)));
            mchk("pkt_sent", 32'(pkt_sent), 32'(m_pkt));
            mchk("drop_count", 32'(drop_count), 32'(m_drop));
            if (m_inflight) begin
                mchk("tx_data", 32'(tx_data), 32'(mq[0]));
                mchk("tx_last", 32'(tx_last), 32'(m_nsent == 8));
            end else begin
                mchk("tx_last_idle", 32'(tx_last), 32'd0);
            end
            if (tx_valid && tx_ready) begin
                log_data.push_back(tx_data);
                log_last.push_back(tx_last);
            end
        end
    end

    task automatic dchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_d++;
        if (act !== exp) begin
            errors_d++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        step();
    endtask

    task automatic pulse(input logic [W-1:0] a0, a1, a2, a3, a4, a5, a6, a7);
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
        reward_done = 1'b1;
        step();
        reward_done = 1'b0;
    endtask

    // mode 0: tx_ready held high; mode 1: tx_ready pattern 1,0,0 repeating
    task automatic run_idle(input int mode, input int budget);
        int k = 0;
        while (tx_busy && k < budget) begin
            tx_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            step();
            k++;
        end
        tx_ready = 1'b1;
        dchk("idle_timeout", 32'(tx_busy), 32'd0);
    endtask

    task automatic chk_log(input string name, input int base, input logic [W-1:0] e [9]);
        dchk({name, "_count"}, 32'(log_data.size()), 32'(base + 9));
        if (log_data.size() >= base + 9) begin
            for (int i = 0; i < 9; i++) begin
                dchk($sformatf("%s_w%0d", name, i), 32'(log_data[base + i]), 32'(e[i]));
            end
            dchk({name, "_last8"}, 32'(log_last[base + 8]), 32'd1);
            dchk({name, "_last7"}, 32'(log_last[base + 7]), 32'd0);
        end
    endtask

    logic [W-1:0] e_basic [9] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                  16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0008};
    logic [W-1:0] e_ifg   [9] = '{16'h1111, 16'h2222, 16'h4444, 16'h8888,
                                  16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'hFFF0};
    logic [W-1:0] e_rst   [9] = '{16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04,
                                  16'h0B05, 16'h0B06, 16'h0B07, 16'h0B08, 16'h0008};
    logic [W-1:0] e_iso   [9] = '{16'h00A0, 16'h0B00, 16'hC000, 16'h000D,
                                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hCBAD};

    initial begin
        int base;
        int n;
        for (int i = 0; i < 8; i++) r[i] = '0;

        nrst = 1'b0;
        step();
        step();
        nrst = 1'b1;
        step();
        dchk("reset_valid", 32'(tx_valid), 32'd0);
        dchk("reset_data", 32'(tx_data), 32'd0);
        dchk("reset_busy", 32'(tx_busy), 32'd0);
        dchk("reset_drop", 32'(drop_count), 32'd0);

        // Basic packet, tx_ready held high
        tx_ready = 1'b1;
        base = log_data.size();
        pulse(16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8);
        dchk("basic_first_word", 32'(tx_data), 32'h0001);
        run_idle(0, 40);
        chk_log("basic", base, e_basic);

        // Backpressure
        base = log_data.size();
        pulse(16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8);
        run_idle(1, 100);
        chk_log("bp", base, e_basic);

        // Inter-frame gap: drop inside the gap, accept 5 cycles after last handshake
        do_reset();
        tx_ready = 1'b1;
        pulse(16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8);
        n = 0;
        while (!pkt_sent && n < 40) begin
            step();
            n++;
        end
        dchk("pkt_sent_seen", 32'(pkt_sent), 32'd1);
        step();
        step();
        pulse(16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD);
        dchk("ifg_drop", 32'(drop_count), 32'd1);
        step();
        base = log_data.size();
        pulse(16'h1111, 16'h2222, 16'h4444, 16'h8888, 16'h0001, 16'h0002, 16'h0004, 16'h0008);
        dchk("ifg_accept", 32'(tx_valid), 32'd1);
        run_idle(0, 40);
        chk_log("ifg", base, e_ifg);
        dchk("ifg_drop_after", 32'(drop_count), 32'd1);

        // Drop counter saturation while stalled mid-packet
        do_reset();
        tx_ready = 1'b1;
        base = log_data.size();
        pulse(16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8);
        step();
        step();
        step();
        tx_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            reward_done = 1'b1;
            step();
            reward_done = 1'b0;
            step();
        end
        dchk("sat_drop", 32'(drop_count), 32'd255);
        dchk("sat_stalled_valid", 32'(tx_valid), 32'd1);
        dchk("sat_stalled_data", 32'(tx_data), 32'h0004);
        run_idle(0, 40);
        chk_log("sat", base, e_basic);

        // Reset mid-packet after word 3 transfers
        do_reset();
        tx_ready = 1'b1;
        pulse(16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 16'h0A05, 16'h0A06, 16'h0A07, 16'h0A08);
        step();
        step();
        step();
        step();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        dchk("mid_rst_valid", 32'(tx_valid), 32'd0);
        dchk("mid_rst_busy", 32'(tx_busy), 32'd0);
        dchk("mid_rst_data", 32'(tx_data), 32'd0);
        dchk("mid_rst_last", 32'(tx_last), 32'd0);
        dchk("mid_rst_drop", 32'(drop_count), 32'd0);
        base = log_data.size();
        pulse(16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04, 16'h0B05, 16'h0B06, 16'h0B07, 16'h0B08);
        dchk("mid_rst_word0", 32'(tx_data), 32'h0B01);
        run_idle(0, 40);
        chk_log("rst", base, e_rst);

        // Input isolation: inputs change right after capture
        base = log_data.size();
        pulse(16'h00A0, 16'h0B00, 16'hC000, 16'h000D, 16'h0, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 8; i++) r[i] = 16'hFFFF;
        run_idle(0, 40);
        chk_log("iso", base, e_iso);

        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks_m + checks_d, errors_m + errors_d);
        $finish;
    end

endmodule
